// File: rtl/prog_loader.sv
// prog_loader: host byte-stream loader and 256 x 14-bit instruction store.
// Frame: length N (0 means 256), N {HI, LO} pairs, checksum byte. Frame bytes
// including the checksum must sum to 0x00 mod 256. Until a valid image is
// present the core is held in reset. After that, inst is served
// combinationally from pc.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [7:0]  pc,
  output logic [13:0] inst,
  output logic        core_rst,
  output logic        load_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_LEN = 3'd0,
    S_HI  = 3'd1,
    S_LO  = 3'd2,
    S_SUM = 3'd3,
    S_RUN = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [5:0]  hi_q, hi_d;
  logic        core_rst_q, core_rst_d;
  logic        load_done_q, load_done_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        xfer;
  logic [7:0]  sum_next;
  logic [13:0] mem [256];

  assign rx_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                    (state_q == S_LO)  || (state_q == S_SUM);
  assign xfer     = rx_valid && rx_ready;
  assign sum_next = sum_q + rx_data;

  // Next-state, datapath updates and registered status decodes.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    mem_we  = 1'b0;
    case (state_q)
      S_LEN: begin
        if (xfer) begin
          n_d     = rx_data;
          idx_d   = 8'd0;
          sum_d   = rx_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (rx_data[7:6] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            hi_d    = rx_data[5:0];
            sum_d   = sum_next;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          mem_we = 1'b1;
          sum_d  = sum_next;
          // N - 1 wraps to 255 when N = 0, giving a 256-entry image.
          if (idx_q == n_q - 8'd1) begin
            state_d = S_SUM;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_HI;
          end
        end
      end
      S_SUM: begin
        if (xfer) state_d = (sum_next == 8'd0) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (reload) state_d = S_LEN;
      end
      default: state_d = S_LEN;
    endcase
    core_rst_d  = (state_d != S_RUN);
    load_done_d = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
  end

  // State and status registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN;
      n_q         <= 8'd0;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      hi_q        <= 6'd0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      core_rst_q  <= core_rst_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  // Instruction store write; never cleared, stale entries are masked on read.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx_q] <= {hi_q, rx_data};
  end

  assign core_rst  = core_rst_q;
  assign load_done = load_done_q;
  assign err       = err_q;

  // Read port: only valid image entries are visible, and only in RUN.
  assign inst = ((state_q == S_RUN) && ((n_q == 8'd0) || (pc < n_q))) ? mem[pc] : 14'h0000;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and instruction store that sits directly upstream of the carbon core's fetch path. It accepts a byte stream from a host link (length, instruction pairs, checksum) and writes 14-bit instructions into a 256-entry store. It holds the core in reset until a complete, checksum-valid image is present. It then serves `inst` combinationally from the core's 8-bit program counter.

## Interface
Parameters:
- none. Widths are fixed: 8-bit PC, 14-bit instruction (6-bit opcode, 8-bit constant), 256 entries.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data is valid this cycle
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs on an edge where rx_valid && rx_ready
- reload  in  1  in RUN or ERR: discard the image and restart loading
- pc  in  8  core program counter
- inst  out  14  instruction at pc; combinational from pc and the store
- core_rst  out  1  reset to the core; high whenever the state is not RUN
- load_done  out  1  high in RUN
- err  out  1  high in ERR

## Operation
- States: LEN, HI, LO, SUM, RUN, ERR. Reset enters LEN.
- Stream format, in order:
  - length byte N. N = 0 means 256 instructions.
  - N pairs of {HI, LO}. The instruction is {HI[5:0], LO}.
  - one checksum byte. The 8-bit sum of every byte in the frame, including the checksum byte, must be 0x00.
- LEN:
  - On transfer: store N, set idx = 0, set sum = rx_data, go to HI.
- HI:
  - On transfer, if rx_data[7:6] != 0: go to ERR.
  - Otherwise latch HI[5:0], add the byte to sum, go to LO.
- LO:
  - On transfer: write mem[idx] = {hi, rx_data} and add the byte to sum.
  - If idx == N − 1 (8-bit arithmetic, so N = 0 gives 255): go to SUM.
  - Otherwise idx += 1 and go to HI.
- SUM:
  - On transfer: if (sum + rx_data) mod 256 == 0, go to RUN; otherwise go to ERR.
- RUN:
  - rx_ready = 0.
  - `inst = mem[pc]` if (N == 0 || pc < N); otherwise `14'h0000`.
  - The store is never cleared. Entries beyond N are masked by this comparison.
- ERR:
  - rx_ready = 0, inst = 0, core_rst = 1.
  - Exited only by rst or reload.
- reload:
  - Sampled only in RUN and ERR. Moves to LEN, clears err and load_done, reasserts core_rst.
  - Ignored in LEN, HI, LO and SUM.
- inst is 0 in every state except RUN.
- rx_ready is high exactly in LEN, HI, LO and SUM.

## Timing
- Reset values: state LEN, rx_ready 1, core_rst 1, load_done 0, err 0, inst 0, idx 0, N 0, sum 0. Store contents are undefined and masked.
- One byte accepted per cycle at most. Back-to-back transfers run at full rate. Gaps with rx_valid low hold all state.
- core_rst, load_done and err are registered state decodes.
  - They change on the edge that accepts the checksum byte, or on the edge that sees the bad byte or reload.
  - The core first leaves reset in the cycle after that edge.
- The store write takes effect on the LO-accept edge. The written entry is readable (once in RUN) from the next cycle.
- inst has zero-cycle latency from pc and settles within the same cycle.
- rst mid-load: returns to LEN next edge; partial image discarded by the N/state masking.
- rst has priority over reload and over any transfer on the same edge.

## Test plan
- Normal load, stream 02 01 23 3F FF 9C at full rate:
  - after the 6th transfer: load_done = 1, core_rst = 0, err = 0.
  - pc = 0 → inst 0x0123; pc = 1 → 0x3FFF; pc = 2 → 0x0000.
- Same stream with rx_valid low on alternate cycles:
  - identical final state.
  - rx_ready stays high until the checksum is accepted.
- Stream 01 41 00:
  - err = 1 after the 2nd transfer; rx_ready = 0; core_rst = 1; inst = 0.
  - reload pulse → state LEN, err = 0, rx_ready = 1.
- Stream 02 01 23 3F FF 9D (bad checksum):
  - err = 1, load_done = 0.
  - Later bytes are not accepted.
- N = 00 with 256 pairs (entry k = {k[5:0], k}) plus the correct checksum:
  - RUN reached.
  - pc = 255 → inst 0x3FFF; pc = 0 → 0x0000.
- rst asserted after the 3rd byte of a load:
  - next cycle: LEN, core_rst = 1.
  - A fresh complete stream then loads correctly.
